// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode prefixes, destination/source codes, special
//               no-op words and FSM state encoding for the instruction
//               decoder and its field-decode sub-module.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Opcode class prefixes, matched against the top bits of the word.
    // Load is identified by bit 7 being clear.
    localparam logic       c_PFX_LOAD  = 1'b0;
    localparam logic [1:0] c_PFX_MOVE  = 2'b10;
    localparam logic [2:0] c_PFX_ALU   = 3'b110;
    localparam logic [3:0] c_PFX_JMP   = 4'b1110;
    localparam logic [3:0] c_PFX_JNZ   = 4'b1111;

    // Special ALU-space words that act as no-ops with their own strobes.
    localparam logic [7:0] c_NOPC8     = 8'hC8;
    localparam logic [7:0] c_NOPCF     = 8'hCF;

    // Destination codes (bit position in reg_en).
    localparam logic [2:0] c_DST_X0    = 3'd0;
    localparam logic [2:0] c_DST_X1    = 3'd1;
    localparam logic [2:0] c_DST_Y0    = 3'd2;
    localparam logic [2:0] c_DST_Y1    = 3'd3;
    localparam logic [2:0] c_DST_O_REG = 3'd4;
    localparam logic [2:0] c_DST_M     = 3'd5;
    localparam logic [2:0] c_DST_I     = 3'd6;
    localparam logic [2:0] c_DST_DM    = 3'd7;

    // Move source codes; code 8 selects the immediate field.
    localparam logic [3:0] c_SRC_X0    = 4'd0;
    localparam logic [3:0] c_SRC_X1    = 4'd1;
    localparam logic [3:0] c_SRC_Y0    = 4'd2;
    localparam logic [3:0] c_SRC_Y1    = 4'd3;
    localparam logic [3:0] c_SRC_R     = 4'd4;
    localparam logic [3:0] c_SRC_M     = 4'd5;
    localparam logic [3:0] c_SRC_I     = 4'd6;
    localparam logic [3:0] c_SRC_DM    = 4'd7;
    localparam logic [3:0] c_SRC_IMM   = 4'd8;

    // Sequencer FSM encoding.
    localparam int         c_STATE_W   = 1;
    localparam logic [c_STATE_W-1:0] c_ST_FLUSH = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN   = 1'b1;

    // Single-bit load enable for a 3-bit destination code.
    function automatic logic [7:0] f_onehot8(input logic [2:0] code);
        return 8'd1 << code;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Purely combinational field decode of one 8-bit instruction
//               word. No state and no run/flush gating; the top gates these.
// Ports       : i_pm_data    - instruction word
//               o_reg_en     - one-hot destination load enable
//               o_source_sel - move source code, 8 = immediate
//               o_x_sel, o_y_sel, o_alu_func, o_alu_en - ALU controls
//               o_jmp, o_jmp_nz - jump strobes
//               o_nopc8, o_nopcf - special no-op strobes
// Revision    : 1.0  initial release
// ============================================================================
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_pm_data,
    output logic [7:0] o_reg_en,
    output logic [3:0] o_source_sel,
    output logic       o_x_sel,
    output logic       o_y_sel,
    output logic [2:0] o_alu_func,
    output logic       o_alu_en,
    output logic       o_jmp,
    output logic       o_jmp_nz,
    output logic       o_nopc8,
    output logic       o_nopcf
);

    logic [2:0] w_mv_dst;
    logic [2:0] w_mv_src;

    assign w_mv_dst = i_pm_data[5:3];
    assign w_mv_src = i_pm_data[2:0];

    always_comb begin
        o_reg_en     = 8'h00;
        o_source_sel = 4'd0;
        o_x_sel      = 1'b0;
        o_y_sel      = 1'b0;
        o_alu_func   = 3'd0;
        o_alu_en     = 1'b0;
        o_jmp        = 1'b0;
        o_jmp_nz     = 1'b0;
        o_nopc8      = 1'b0;
        o_nopcf      = 1'b0;

        if (i_pm_data[7] == c_PFX_LOAD) begin
            o_reg_en     = f_onehot8(i_pm_data[6:4]);
            o_source_sel = c_SRC_IMM;
        end else if (i_pm_data[7:6] == c_PFX_MOVE) begin
            o_source_sel = {1'b0, w_mv_src};
            // o_reg <- r is meaningless (r is the ALU result) and is
            // treated as a no-op move.
            if (!(w_mv_dst == c_DST_O_REG && {1'b0, w_mv_src} == c_SRC_R)) begin
                o_reg_en = f_onehot8(w_mv_dst);
            end
        end else if (i_pm_data[7:5] == c_PFX_ALU) begin
            // The two no-op words sit inside the ALU space and must not
            // touch the ALU or the zero flag.
            if (i_pm_data == c_NOPC8) begin
                o_nopc8 = 1'b1;
            end else if (i_pm_data == c_NOPCF) begin
                o_nopcf = 1'b1;
            end else begin
                o_alu_en   = 1'b1;
                o_x_sel    = i_pm_data[4];
                o_y_sel    = i_pm_data[3];
                o_alu_func = i_pm_data[2:0];
            end
        end else if (i_pm_data[7:4] == c_PFX_JMP) begin
            o_jmp = 1'b1;
        end else if (i_pm_data[7:4] == c_PFX_JNZ) begin
            o_jmp_nz = 1'b1;
        end
    end

endmodule : instr_field_decode
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder
// Description : Zero-latency instruction decoder with a FLUSH/RUN sequencer,
//               zero flag, instruction register and saturating counter.
// Ports       : clk         - system clock, rising edge
//               sync_reset  - synchronous active-high reset
//               pm_data     - instruction word at current pc
//               alu_zero    - ALU result-is-zero
//               ir          - registered last decoded word
//               jmp, jmp_nz, dont_jmp - sequencer controls
//               NOPC8, NOPCF - special no-op strobes
//               reg_en      - one-hot destination load enable
//               source_sel  - move source (8 = immediate)
//               x_sel, y_sel, alu_func, alu_en - ALU controls
//               instr_count - saturating executed-instruction count
// Revision    : 1.0  initial release
// ============================================================================
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        sync_reset,
    input  logic [7:0]  pm_data,
    input  logic        alu_zero,
    output logic [7:0]  ir,
    output logic        jmp,
    output logic        jmp_nz,
    output logic        dont_jmp,
    output logic        NOPC8,
    output logic        NOPCF,
    output logic [7:0]  reg_en,
    output logic [3:0]  source_sel,
    output logic        x_sel,
    output logic        y_sel,
    output logic [2:0]  alu_func,
    output logic        alu_en,
    output logic [15:0] instr_count
);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_zero_flag;
    logic [7:0]           r_ir;
    logic [15:0]          r_instr_count;

    logic       w_run;
    logic [7:0] w_reg_en;
    logic [3:0] w_source_sel;
    logic       w_x_sel;
    logic       w_y_sel;
    logic [2:0] w_alu_func;
    logic       w_alu_en;
    logic       w_jmp;
    logic       w_jmp_nz;
    logic       w_nopc8;
    logic       w_nopcf;

    instr_field_decode u_field_decode (
        .i_pm_data    (pm_data),
        .o_reg_en     (w_reg_en),
        .o_source_sel (w_source_sel),
        .o_x_sel      (w_x_sel),
        .o_y_sel      (w_y_sel),
        .o_alu_func   (w_alu_func),
        .o_alu_en     (w_alu_en),
        .o_jmp        (w_jmp),
        .o_jmp_nz     (w_jmp_nz),
        .o_nopc8      (w_nopc8),
        .o_nopcf      (w_nopcf)
    );

    // Reset kills the strobes in the very cycle it is asserted, not just
    // from the next edge on.
    assign w_run = (r_state == c_ST_RUN) && !sync_reset;

    assign reg_en      = w_run ? w_reg_en     : 8'h00;
    assign source_sel  = w_run ? w_source_sel : 4'd0;
    assign x_sel       = w_run & w_x_sel;
    assign y_sel       = w_run & w_y_sel;
    assign alu_func    = w_run ? w_alu_func   : 3'd0;
    assign alu_en      = w_run & w_alu_en;
    assign jmp         = w_run & w_jmp;
    assign jmp_nz      = w_run & w_jmp_nz;
    assign NOPC8       = w_run & w_nopc8;
    assign NOPCF       = w_run & w_nopcf;

    assign ir          = r_ir;
    assign dont_jmp    = r_zero_flag;
    assign instr_count = r_instr_count;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state       <= c_ST_FLUSH;
            r_ir          <= 8'h00;
            r_zero_flag   <= 1'b0;
            r_instr_count <= 16'h0000;
        end else begin
            case (r_state)
                c_ST_FLUSH: begin
                    r_state <= c_ST_RUN;
                    r_ir    <= 8'h00;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_ir    <= pm_data;
                    if (r_instr_count != 16'hFFFF) begin
                        r_instr_count <= r_instr_count + 16'd1;
                    end
                end
            endcase
            // alu_en is already gated by state, so FLUSH never updates it.
            if (alu_en) begin
                r_zero_flag <= alu_zero;
            end
        end
    end

endmodule : instruction_decoder
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decoder
// Description : Directed self-checking bench for instruction_decoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_decoder;

    logic        clk;
    logic        sync_reset;
    logic [7:0]  pm_data;
    logic        alu_zero;
    logic [7:0]  ir;
    logic        jmp;
    logic        jmp_nz;
    logic        dont_jmp;
    logic        NOPC8;
    logic        NOPCF;
    logic [7:0]  reg_en;
    logic [3:0]  source_sel;
    logic        x_sel;
    logic        y_sel;
    logic [2:0]  alu_func;
    logic        alu_en;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    instruction_decoder u_dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .pm_data     (pm_data),
        .alu_zero    (alu_zero),
        .ir          (ir),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .NOPC8       (NOPC8),
        .NOPCF       (NOPCF),
        .reg_en      (reg_en),
        .source_sel  (source_sel),
        .x_sel       (x_sel),
        .y_sel       (y_sel),
        .alu_func    (alu_func),
        .alu_en      (alu_en),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sync_reset = 1'b1;
        pm_data    = 8'h00;
        alu_zero   = 1'b0;
        cyc();
        cyc();
        chk("rst_ir",     32'(ir), 32'h00);
        chk("rst_count",  32'(instr_count), 32'h0);
        chk("rst_dontj",  32'(dont_jmp), 32'h0);
        chk("rst_reg_en", 32'(reg_en), 32'h00);

        // Load 0x25: FLUSH cycle first, then decode to y0 from immediate.
        sync_reset = 1'b0;
        pm_data    = 8'h25;
        #1;
        chk("flush_reg_en", 32'(reg_en), 32'h00);
        chk("flush_srcsel", 32'(source_sel), 32'h0);
        cyc();
        chk("load_reg_en", 32'(reg_en), 32'h04);
        chk("load_srcsel", 32'(source_sel), 32'h8);
        chk("flush_ir",    32'(ir), 32'h00);
        cyc();
        chk("load_ir",     32'(ir), 32'h25);
        chk("count_1",     32'(instr_count), 32'h1);

        // ALU 0xC2 with zero result, then jmp_nz.
        pm_data  = 8'hC2;
        alu_zero = 1'b1;
        #1;
        chk("alu_en",     32'(alu_en), 32'h1);
        chk("alu_func",   32'(alu_func), 32'h2);
        chk("alu_xy",     32'({x_sel, y_sel}), 32'h0);
        chk("alu_reg_en", 32'(reg_en), 32'h00);
        cyc();
        pm_data  = 8'hF3;
        alu_zero = 1'b0;
        #1;
        chk("jnz_strobe", 32'(jmp_nz), 32'h1);
        chk("jnz_jmp",    32'(jmp), 32'h0);
        chk("jnz_dontj",  32'(dont_jmp), 32'h1);
        cyc();

        // NOPCF must not touch the ALU or the flag.
        pm_data  = 8'hCF;
        alu_zero = 1'b0;
        #1;
        chk("nopcf",       32'(NOPCF), 32'h1);
        chk("nopcf_alu",   32'(alu_en), 32'h0);
        chk("nopcf_nopc8", 32'(NOPC8), 32'h0);
        cyc();
        chk("nopcf_dontj", 32'(dont_jmp), 32'h1);

        pm_data = 8'hC8;
        #1;
        chk("nopc8",     32'(NOPC8), 32'h1);
        chk("nopc8_alu", 32'(alu_en), 32'h0);
        cyc();
        chk("nopc8_dontj", 32'(dont_jmp), 32'h1);

        pm_data = 8'hE5;
        #1;
        chk("jmp",       32'(jmp), 32'h1);
        chk("jmp_jnz",   32'(jmp_nz), 32'h0);
        cyc();

        // Moves: y1 <- y0, then the o_reg <- r no-op.
        pm_data = 8'h9A;
        #1;
        chk("mov_reg_en", 32'(reg_en), 32'h08);
        chk("mov_srcsel", 32'(source_sel), 32'h2);
        cyc();
        pm_data = 8'hA4;
        #1;
        chk("mov44_reg_en", 32'(reg_en), 32'h00);
        cyc();

        // ALU 0xDD: x=1, y=1, func=5, non-zero result clears the flag.
        pm_data  = 8'hDD;
        alu_zero = 1'b0;
        #1;
        chk("alu2_en",   32'(alu_en), 32'h1);
        chk("alu2_xy",   32'({x_sel, y_sel}), 32'h3);
        chk("alu2_func", 32'(alu_func), 32'h5);
        cyc();
        chk("alu2_dontj", 32'(dont_jmp), 32'h0);

        pm_data = 8'h7F;
        #1;
        chk("load_dm", 32'(reg_en), 32'h80);
        cyc();
        // RUN cycles so far: 25,C2,F3,CF,C8,E5,9A,A4,DD,7F
        chk("count_10", 32'(instr_count), 32'd10);

        // Reset during an ALU op with a zero result: no strobes, no flag.
        pm_data    = 8'hC0;
        alu_zero   = 1'b1;
        sync_reset = 1'b1;
        #1;
        chk("rstalu_en",    32'(alu_en), 32'h0);
        chk("rstalu_strb",  32'({reg_en, jmp, jmp_nz, NOPC8, NOPCF}), 32'h0);
        cyc();
        chk("rstalu_dontj", 32'(dont_jmp), 32'h0);
        chk("rstalu_count", 32'(instr_count), 32'h0);
        sync_reset = 1'b0;
        #1;
        chk("flush_alu_en", 32'(alu_en), 32'h0);
        cyc();
        chk("flush_dontj",  32'(dont_jmp), 32'h0);

        // Saturation of the counter.
        pm_data  = 8'h00;
        alu_zero = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_ffff", 32'(instr_count), 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_stay", 32'(instr_count), 32'hFFFF);

        sync_reset = 1'b1;
        cyc();
        sync_reset = 1'b0;
        #1;
        chk("sat_rst_count", 32'(instr_count), 32'h0);
        chk("sat_rst_flush", 32'(reg_en), 32'h00);
        cyc();
        chk("sat_run_reg_en", 32'(reg_en), 32'h01);
        chk("sat_run_count0", 32'(instr_count), 32'h0);
        cyc();
        chk("sat_run_count1", 32'(instr_count), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instruction_decoder
`default_nettype wire

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port sync_reset, input, 1, synchronous reset, active-high (fixed).
REQ-003 SHALL have port pm_data, input, 8, instruction word at the current pc, valid for the whole cycle.
REQ-004 SHALL have port alu_zero, input, 1, ALU result-equals-zero, combinational during an ALU instruction.
REQ-005 SHALL have port ir, output, 8, registered copy of the last decoded pm_data.
REQ-006 SHALL have ports jmp, jmp_nz, dont_jmp, output, 1 each, to the program sequencer.
REQ-007 SHALL have ports NOPC8 and NOPCF, output, 1 each, special no-op strobes.
REQ-008 SHALL have port reg_en, output, 8, load enable one-hot by destination code (0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm).
REQ-009 SHALL have port source_sel, output, 4, 0-7 move source code (0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm); 8 immediate.
REQ-010 SHALL have ports x_sel, y_sel, output, 1 each; alu_func, output, 3; alu_en, output, 1.
REQ-011 SHALL have port instr_count, output, 16, saturating count of executed instructions.

Function
REQ-012 SHALL classify pm_data: 0xxx_xxxx load, 10xx_xxxx move, 110x_xxxx ALU, 1110_xxxx jmp, 1111_xxxx jmp_nz.
REQ-013 SHALL decode outputs combinationally from pm_data in the same cycle (zero latency), gated by FSM state.
REQ-014 Load: reg_en[pm_data[6:4]]=1, source_sel=8; no other enable.
REQ-015 Move: reg_en[pm_data[5:3]]=1, source_sel={0,pm_data[2:0]}; move with dst==src==4 SHALL assert no reg_en.
REQ-016 ALU: alu_en=1, x_sel=pm_data[4], y_sel=pm_data[3], alu_func=pm_data[2:0]; reg_en all zero.
REQ-017 pm_data==8'hC8 SHALL assert NOPC8 only; 8'hCF SHALL assert NOPCF only; neither asserts alu_en or updates the flag.
REQ-018 jmp=1 for 1110 opcode; jmp_nz=1 for 1111 opcode; both zero otherwise.
REQ-019 Zero flag register SHALL load alu_zero on the clock edge ending a cycle with alu_en=1; otherwise hold.
REQ-020 dont_jmp SHALL equal the zero flag register output (jump not taken when last ALU result was zero).
REQ-021 ir SHALL load pm_data every RUN cycle; hold 8'h00 in FLUSH.
REQ-022 instr_count SHALL increment by 1 each RUN cycle; SHALL stick at 16'hFFFF, no wrap.
REQ-023 FSM states FLUSH, RUN; FLUSH -> RUN unconditionally after one cycle; RUN -> RUN; any state -> FLUSH on sync_reset.
REQ-024 In FLUSH all strobes (reg_en, alu_en, jmp, jmp_nz, NOPC8, NOPCF) SHALL be zero; source_sel, x_sel, y_sel, alu_func 0.
REQ-025 Unused/undefined fields SHALL never assert more than one reg_en bit.

Reset
REQ-026 On sync_reset: state=FLUSH, ir=8'h00, zero flag=0 (dont_jmp=0), instr_count=0.
REQ-027 sync_reset mid-ALU instruction SHALL block the flag update that cycle.
REQ-028 sync_reset SHALL zero all combinational strobes in the same cycle it is asserted.

Structure
REQ-029 Opcode patterns, destination/source codes, NOPC8/NOPCF constants and FSM state encoding SHALL reside in shared package cpu_pkg.
REQ-030 Field decoding SHALL be one sub-module, instr_field_decode (pure combinational); registers and FSM in the top.

Verification
REQ-031 Reset then pm_data=8'h25 -> cycle 1 (FLUSH) reg_en=0; cycle 2 reg_en=8'h04, source_sel=8, ir=8'h25 next edge.
REQ-032 pm_data=8'hC2 with alu_zero=1, then 8'hF3 -> alu_en=1 then jmp_nz=1, dont_jmp=1.
REQ-033 pm_data=8'hCF with alu_zero=0 after flag=1 -> NOPCF=1, alu_en=0, dont_jmp stays 1.
REQ-034 pm_data=8'h9A -> reg_en=8'h08, source_sel=2; pm_data=8'hA4 -> reg_en=0.
REQ-035 Run 70000 RUN cycles -> instr_count=16'hFFFF, stays; sync_reset -> 0, FLUSH one cycle.
REQ-036 sync_reset asserted during 8'hC0 with alu_zero=1 -> flag remains 0, all strobes 0 that cycle.
